// File: rtl/atom_video_out_if.sv
// Core-side pixel bus into the video output stage and the expanded video bus out of it.
interface atom_video_out_if;
    logic [1:0] r_in;
    logic [1:0] g_in;
    logic [1:0] b_in;
    logic       hs_n_in;
    logic       vs_n_in;
    logic       ce_14;
    logic       ce_pix;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       de;
    logic       h_locked;

    modport master (
        output r_in, g_in, b_in, hs_n_in, vs_n_in,
        input  ce_14, ce_pix, R, G, B, hsync, vsync, hblank, vblank, de, h_locked
    );

    modport slave (
        input  r_in, g_in, b_in, hs_n_in, vs_n_in,
        output ce_14, ce_pix, R, G, B, hsync, vsync, hblank, vblank, de, h_locked
    );
endinterface

// File: rtl/atom_video_out.sv
// Atom video output: clock enables, 2-bit to 8-bit colour expansion, sync/blank
// generation from the core syncs and a line-length lock detector.
module atom_video_out #(
    parameter int unsigned HB_BACK  = 96,
    parameter int unsigned H_ACTIVE = 512,
    parameter int unsigned VB_BACK  = 35,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic              clk_42,
    input  logic              reset,
    atom_video_out_if.slave   bus
);

    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    div_q, div_d;
    logic          ph_q, ph_d;
    logic          ce_14_q, ce_14_d;
    logic          ce_pix_q, ce_pix_d;

    logic [1:0]    r_s_q, r_s_d, g_s_q, g_s_d, b_s_q, b_s_d;
    logic          hs_s_q, hs_s_d, vs_s_q, vs_s_d;

    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CW-1:0] len_cur_q, len_cur_d, len_prev_q, len_prev_d;
    logic          locked_q, locked_d;

    logic [7:0]    r_o_q, r_o_d, g_o_q, g_o_d, b_o_q, b_o_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;

    logic          hs_start, vs_start, h_act, v_act;

    function automatic logic [7:0] expand(input logic [1:0] x);
        return {x[1], x[1], x[1], x[0], x[0], x[0], x[1], x[0]};
    endfunction

    // Falling edge of the core sync between the previous and the current pixel sample
    assign hs_start = hs_s_q & ~bus.hs_n_in;
    assign vs_start = vs_s_q & ~bus.vs_n_in;

    // Window tests use the counters aligned with the sample register stage
    assign h_act = (32'(hcnt_q) >= HB_BACK) && (32'(hcnt_q) < HB_BACK + H_ACTIVE);
    assign v_act = (32'(vcnt_q) >= VB_BACK) && (32'(vcnt_q) < VB_BACK + V_ACTIVE);

    always_comb begin
        div_d      = (div_q == 2'd2) ? 2'd0 : div_q + 2'd1;
        ce_14_d    = (div_q == 2'd1);
        ce_pix_d   = (div_q == 2'd1) && ph_q;
        ph_d       = ph_q ^ ce_14_q;
        r_s_d      = r_s_q;
        g_s_d      = g_s_q;
        b_s_d      = b_s_q;
        hs_s_d     = hs_s_q;
        vs_s_d     = vs_s_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        len_cur_d  = len_cur_q;
        len_prev_d = len_prev_q;
        locked_d   = locked_q;
        r_o_d      = r_o_q;
        g_o_d      = g_o_q;
        b_o_d      = b_o_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        hblank_d   = hblank_q;
        vblank_d   = vblank_q;
        de_d       = de_q;

        if (ce_pix_q) begin
            r_s_d  = bus.r_in;
            g_s_d  = bus.g_in;
            b_s_d  = bus.b_in;
            hs_s_d = bus.hs_n_in;
            vs_s_d = bus.vs_n_in;

            hcnt_d = hs_start ? '0 : ((hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1);
            if (vs_start) begin
                vcnt_d = '0;
            end else if (hs_start) begin
                vcnt_d = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 10'd1;
            end

            // Lock compares the line just finished with the one before it
            if (hs_start) begin
                len_cur_d  = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
                len_prev_d = len_cur_q;
                locked_d   = (len_cur_d == len_prev_d) && (len_cur_d != CNT_MAX);
            end else if (hcnt_q == CNT_MAX) begin
                locked_d = 1'b0;
            end

            hblank_d = ~h_act;
            vblank_d = ~v_act;
            de_d     = h_act & v_act;
            r_o_d    = de_d ? expand(r_s_q) : 8'h00;
            g_o_d    = de_d ? expand(g_s_q) : 8'h00;
            b_o_d    = de_d ? expand(b_s_q) : 8'h00;
            hsync_d  = ~hs_s_q;
            vsync_d  = ~vs_s_q;
        end
    end

    always_ff @(posedge clk_42) begin
        if (reset) begin
            div_q      <= 2'd0;
            ph_q       <= 1'b0;
            ce_14_q    <= 1'b0;
            ce_pix_q   <= 1'b0;
            r_s_q      <= 2'd0;
            g_s_q      <= 2'd0;
            b_s_q      <= 2'd0;
            hs_s_q     <= 1'b1;
            vs_s_q     <= 1'b1;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            len_cur_q  <= '0;
            len_prev_q <= '0;
            locked_q   <= 1'b0;
            r_o_q      <= 8'h00;
            g_o_q      <= 8'h00;
            b_o_q      <= 8'h00;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            hblank_q   <= 1'b1;
            vblank_q   <= 1'b1;
            de_q       <= 1'b0;
        end else begin
            div_q      <= div_d;
            ph_q       <= ph_d;
            ce_14_q    <= ce_14_d;
            ce_pix_q   <= ce_pix_d;
            r_s_q      <= r_s_d;
            g_s_q      <= g_s_d;
            b_s_q      <= b_s_d;
            hs_s_q     <= hs_s_d;
            vs_s_q     <= vs_s_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            len_cur_q  <= len_cur_d;
            len_prev_q <= len_prev_d;
            locked_q   <= locked_d;
            r_o_q      <= r_o_d;
            g_o_q      <= g_o_d;
            b_o_q      <= b_o_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
            de_q       <= de_d;
        end
    end

    assign bus.ce_14    = ce_14_q;
    assign bus.ce_pix   = ce_pix_q;
    assign bus.R        = r_o_q;
    assign bus.G        = g_o_q;
    assign bus.B        = b_o_q;
    assign bus.hsync    = hsync_q;
    assign bus.vsync    = vsync_q;
    assign bus.hblank   = hblank_q;
    assign bus.vblank   = vblank_q;
    assign bus.de       = de_q;
    assign bus.h_locked = locked_q;

endmodule

// File: tb/tb_atom_video_out.sv
// Directed bench for atom_video_out: enable cadence, colour/blank timing, line lock,
// missing hsync, coincident syncs and mid-line reset. Vertical window shrunk to 2..4.
module tb_atom_video_out;

    logic clk_42 = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    atom_video_out_if vif ();

    atom_video_out #(
        .HB_BACK (96),
        .H_ACTIVE(512),
        .VB_BACK (2),
        .V_ACTIVE(3)
    ) dut (
        .clk_42(clk_42),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk_42 = ~clk_42;

    task automatic tick();
        @(posedge clk_42);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel and advance past the ce_pix pulse that samples it
    task automatic pix(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                       input logic hs_n, input logic vs_n);
        bit done;
        done        = 1'b0;
        vif.r_in    = r;
        vif.g_in    = g;
        vif.b_in    = b;
        vif.hs_n_in = hs_n;
        vif.vs_n_in = vs_n;
        for (int k = 0; k < 8 && !done; k++) begin
            if (vif.ce_pix) done = 1'b1;
            tick();
        end
        if (!done) chk("ce_pix_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string w);
        chk({w, "_R"},        32'(vif.R),        32'h00);
        chk({w, "_G"},        32'(vif.G),        32'h00);
        chk({w, "_B"},        32'(vif.B),        32'h00);
        chk({w, "_hsync"},    32'(vif.hsync),    32'd0);
        chk({w, "_vsync"},    32'(vif.vsync),    32'd0);
        chk({w, "_hblank"},   32'(vif.hblank),   32'd1);
        chk({w, "_vblank"},   32'(vif.vblank),   32'd1);
        chk({w, "_de"},       32'(vif.de),       32'd0);
        chk({w, "_h_locked"}, 32'(vif.h_locked), 32'd0);
        chk({w, "_ce_14"},    32'(vif.ce_14),    32'd0);
        chk({w, "_ce_pix"},   32'(vif.ce_pix),   32'd0);
    endtask

    // Called in cycle 1 after reset release: ce_14 every 3rd cycle, ce_pix every 6th
    task automatic ce_sweep(input int n);
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("ce_14_c%0d", c),  32'(vif.ce_14),  32'((c % 3) == 0));
            chk($sformatf("ce_pix_c%0d", c), 32'(vif.ce_pix), 32'((c % 6) == 0));
            tick();
        end
    endtask

    // One line: hs_n low for the first 64 pixels; outputs after pixel i show sample i-1
    task automatic run_line(input int ln, input int len, input bit vs_low,
                            input logic [1:0] r, input logic [1:0] g, input logic [1:0] b,
                            input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                            input bit exp_vb, input bit exp_lock);
        for (int i = 0; i < len; i++) begin
            int h;
            bit hb;
            bit de;
            h = i - 1;
            pix(r, g, b, (i < 64) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1);
            if (i == 0) chk($sformatf("L%0d_lock_at_start", ln), 32'(vif.h_locked), 32'(exp_lock));
            if (h == 0 || h == 63) chk($sformatf("L%0d_hsync_h%0d", ln, h), 32'(vif.hsync), 32'd1);
            if (h == 64) chk($sformatf("L%0d_hsync_h64", ln), 32'(vif.hsync), 32'd0);
            if (h == 0 || h == 64) chk($sformatf("L%0d_vsync_h%0d", ln, h), 32'(vif.vsync), 32'(vs_low));
            if (h == 95 || h == 96 || h == 607 || h == 608 || h == 1050) begin
                hb = !(h >= 96 && h < 608);
                de = !hb && !exp_vb;
                chk($sformatf("L%0d_hblank_h%0d", ln, h), 32'(vif.hblank), 32'(hb));
                chk($sformatf("L%0d_vblank_h%0d", ln, h), 32'(vif.vblank), 32'(exp_vb));
                chk($sformatf("L%0d_de_h%0d", ln, h),     32'(vif.de),     32'(de));
                chk($sformatf("L%0d_R_h%0d", ln, h), 32'(vif.R), de ? 32'(er) : 32'h00);
                chk($sformatf("L%0d_G_h%0d", ln, h), 32'(vif.G), de ? 32'(eg) : 32'h00);
                chk($sformatf("L%0d_B_h%0d", ln, h), 32'(vif.B), de ? 32'(eb) : 32'h00);
            end
            if (i == 1023) chk($sformatf("L%0d_lock_before_sat", ln), 32'(vif.h_locked), 32'(exp_lock));
            if (i == 1024) chk($sformatf("L%0d_lock_after_sat", ln), 32'(vif.h_locked), 32'd0);
            if (i == len - 1)
                chk($sformatf("L%0d_lock_at_end", ln), 32'(vif.h_locked), (len > 1024) ? 32'd0 : 32'(exp_lock));
        end
    endtask

    initial begin
        reset       = 1'b1;
        vif.r_in    = 2'd0;
        vif.g_in    = 2'd0;
        vif.b_in    = 2'd0;
        vif.hs_n_in = 1'b1;
        vif.vs_n_in = 1'b1;
        tick();
        tick();
        tick();
        check_reset_outputs("por");

        reset = 1'b0;
        ce_sweep(24);

        // ln, len, vs_low, rgb in, expected rgb, vblank, lock at line start
        run_line(0,  912, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        run_line(1,  912, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        run_line(2,  912, 1'b0, 2'd1, 2'd2, 2'd3, 8'h1D, 8'hE2, 8'hFF, 1'b0, 1'b1);
        run_line(3,  910, 1'b0, 2'd2, 2'd3, 2'd1, 8'hE2, 8'hFF, 8'h1D, 1'b0, 1'b1);
        run_line(4,  912, 1'b0, 2'd3, 2'd1, 2'd2, 8'hFF, 8'h1D, 8'hE2, 1'b0, 1'b0);
        run_line(5,  912, 1'b0, 2'd3, 2'd3, 2'd3, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
        run_line(6, 1100, 1'b0, 2'd1, 2'd1, 2'd1, 8'h1D, 8'h1D, 8'h1D, 1'b1, 1'b1);
        run_line(7,  200, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        run_line(8,  200, 1'b0, 2'd1, 2'd1, 2'd1, 8'h1D, 8'h1D, 8'h1D, 1'b1, 1'b0);
        run_line(9,  200, 1'b0, 2'd1, 2'd1, 2'd1, 8'h1D, 8'h1D, 8'h1D, 1'b0, 1'b1);
        run_line(10, 151, 1'b0, 2'd2, 2'd2, 2'd2, 8'hE2, 8'hE2, 8'hE2, 1'b0, 1'b1);

        chk("midline_pre_de", 32'(vif.de), 32'd1);
        chk("midline_pre_R",  32'(vif.R),  32'hE2);

        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("midline");
        tick();
        reset = 1'b0;
        ce_sweep(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
